mu2cgra_stream_ctrl: RTL and testbench

- Sequences matrix-unit vector traffic into the CGRA's matrix-unit input port.
- Software sets a transfer length and pulses start. The block admits exactly that many 32-lane vectors from the matrix unit, buffers them in a small FIFO, and issues them to the CGRA under valid/ready.
- Signals completion with a one-cycle done pulse, suitable for the interrupt aggregator. Sits between the matrix-unit boundary and the Garnet mu2cgra/mu2cgra_valid/cgra2mu_ready ports.

---
 rtl/mu2cgra_stream_ctrl.sv | 126 ++++++++++++
 tb/tb_mu2cgra_stream_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mu2cgra_stream_ctrl.sv
// Admits a programmed number of matrix-unit vectors, buffers them in a small
// FIFO and issues them to the CGRA mu2cgra port under valid/ready.
//
// state | meaning
// IDLE  | waiting for start; FIFO empty, no handshakes
// RUN   | accepting vectors from the matrix unit and issuing to the CGRA
// DRAIN | all vectors accepted; emptying the FIFO into the CGRA
// DONE  | one-cycle completion pulse
module mu2cgra_stream_ctrl #(
  parameter int NUM_LANES  = 32,
  parameter int LANE_WIDTH = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CNT_WIDTH-1:0]            cfg_num_vectors,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic [CNT_WIDTH-1:0]            issued_cnt,
  input  logic                            mu_valid,
  output logic                            mu_ready,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] mu_data,
  output logic                            cgra_valid,
  input  logic                            cgra_ready,
  output logic [NUM_LANES*LANE_WIDTH-1:0] cgra_data
);

  localparam int DW = NUM_LANES * LANE_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] accepted_cnt;
  logic [CNT_WIDTH-1:0] acc_nxt, iss_nxt;
  logic [DW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [OW-1:0]        occ;
  logic [DW-1:0]        data_hold;
  logic                 active, fifo_full, fifo_empty;
  logic                 push, pop, flush, accept_start;

  assign active       = (state == RUN) || (state == DRAIN);
  assign fifo_full    = (occ == FULL_OCC);
  assign fifo_empty   = (occ == '0);
  assign flush        = active && abort;
  assign accept_start = (state == IDLE) && start;

  // mu_ready is built from registered state only, so no path from cgra_ready.
  assign mu_ready   = (state == RUN) && !fifo_full && (accepted_cnt != len_q);
  assign cgra_valid = active && !fifo_empty;
  assign cgra_data  = cgra_valid ? mem[rd_ptr] : data_hold;
  assign push       = mu_valid && mu_ready;
  assign pop        = cgra_valid && cgra_ready;
  assign busy       = active;
  assign done       = (state == DONE);

  assign acc_nxt = accepted_cnt + {{(CNT_WIDTH-1){1'b0}}, push};
  assign iss_nxt = issued_cnt + {{(CNT_WIDTH-1){1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (cfg_num_vectors != '0) ? RUN : DONE;
      RUN: begin
        if (abort)                state_nxt = IDLE;
        else if (acc_nxt == len_q) state_nxt = (iss_nxt == len_q) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (abort)                state_nxt = IDLE;
        else if (iss_nxt == len_q) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      accepted_cnt <= '0;
      issued_cnt   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      data_hold    <= '0;
    end else begin
      state     <= state_nxt;
      data_hold <= cgra_data;
      if (accept_start) begin
        len_q        <= cfg_num_vectors;
        accepted_cnt <= '0;
        issued_cnt   <= '0;
      end else if (active) begin
        accepted_cnt <= acc_nxt;
        issued_cnt   <= iss_nxt;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mu_data;
  end

endmodule

// File: tb/tb_mu2cgra_stream_ctrl.sv
// Directed scoreboard bench for mu2cgra_stream_ctrl: accepted vectors are
// queued on the input handshake and compared when the CGRA side pops them.
module tb_mu2cgra_stream_ctrl;
  localparam int NL = 32;
  localparam int LW = 17;
  localparam int DW = NL * LW;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] cfg_num_vectors = '0;
  logic          start = 1'b0, abort = 1'b0;
  logic          mu_valid = 1'b0, cgra_ready = 1'b0;
  logic [DW-1:0] mu_data;
  logic          busy, done, mu_ready, cgra_valid;
  logic [CW-1:0] issued_cnt;
  logic [DW-1:0] cgra_data;

  always #5 clk = ~clk;

  mu2cgra_stream_ctrl dut (
    .clk(clk), .reset(reset), .cfg_num_vectors(cfg_num_vectors),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .issued_cnt(issued_cnt), .mu_valid(mu_valid), .mu_ready(mu_ready),
    .mu_data(mu_data), .cgra_valid(cgra_valid), .cgra_ready(cgra_ready),
    .cgra_data(cgra_data)
  );

  int n_assert = 0, n_fail = 0;
  logic [DW-1:0] sb[$];
  int cyc = 0, src_k = 0, n;
  int xfer_len, xfer_acc, pops, done_cnt, done_cyc;
  int first_push_cyc, last_push_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
  bit hold_pending = 1'b0;
  logic [DW-1:0] held_data;

  function automatic logic [DW-1:0] make_vec(input int k);
    logic [DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*LW +: LW] = LW'(k * NL + i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_xfer(input int len);
    xfer_len = len; xfer_acc = 0; pops = 0; done_cnt = 0; done_cyc = -1;
    first_push_cyc = -1; last_push_cyc = -1; first_valid_cyc = -1;
    first_pop_cyc = -1; last_pop_cyc = -1;
  endtask

  // One clock: sample handshakes away from the edge, score, then advance.
  task automatic step();
    logic do_push, do_pop;
    logic [DW-1:0] exp;
    #1;
    do_push = mu_valid && mu_ready;
    do_pop  = cgra_valid && cgra_ready;
    if (hold_pending) begin
      chk("hold_valid", cgra_valid, 1);
      chk("hold_data", cgra_data, held_data);
    end
    if (busy && xfer_acc == xfer_len) chk("mu_ready_closed", mu_ready, 0);
    if (do_push) begin
      sb.push_back(mu_data);
      xfer_acc++;
      if (first_push_cyc < 0) first_push_cyc = cyc;
      last_push_cyc = cyc;
    end
    if (cgra_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (do_pop) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL pop_nonempty observed=%0d expected>0", sb.size());
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("pop_data", cgra_data, exp);
      end
      pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    hold_pending = cgra_valid && !do_pop && !abort && !reset;
    held_data = cgra_data;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (do_push) begin
      src_k++;
      mu_data = make_vec(src_k);
    end
  endtask

  task automatic run_until_done(input string tag, input int budget, input bit toggle);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      if (toggle) begin
        mu_valid   = (k % 2 == 0);
        cgra_ready = (k % 2 == 1);
      end
      step();
      k++;
    end
    #1;
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_issued"}, issued_cnt, xfer_len);
    chk({tag, "_pops"}, pops, xfer_len);
    chk({tag, "_done_latency"}, done_cyc, last_pop_cyc + 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mu_data = make_vec(0);
    // Reset state
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_mu_ready", mu_ready, 0);
    chk("rst_cgra_valid", cgra_valid, 0);
    chk("rst_cgra_data", cgra_data, 0);

    // Streaming, length 8
    begin_xfer(8);
    cfg_num_vectors = 8; start = 1; mu_valid = 1; cgra_ready = 1;
    step();
    start = 0;
    run_until_done("stream", 40, 0);
    chk("stream_first_valid", first_valid_cyc, first_push_cyc + 1);
    chk("stream_throughput", last_pop_cyc - first_pop_cyc, 7);

    // Backpressure, length 10, six stall cycles
    begin_xfer(10);
    cfg_num_vectors = 10; start = 1; mu_valid = 1; cgra_ready = 1;
    step();
    start = 0;
    repeat (3) step();
    cgra_ready = 0;
    repeat (6) step();
    #1;
    chk("bp_mu_ready", mu_ready, 0);
    chk("bp_occupancy", sb.size(), 4);
    chk("bp_valid", cgra_valid, 1);
    cgra_ready = 1;
    run_until_done("bp", 60, 0);

    // Bursty source and sink, length 5
    begin_xfer(5);
    cfg_num_vectors = 5; start = 1; mu_valid = 0; cgra_ready = 0;
    step();
    start = 0;
    run_until_done("burst", 60, 1);
    chk("burst_accepts", xfer_acc, 5);
    chk("burst_drain_seen", last_pop_cyc > last_push_cyc, 1);

    // Zero length
    begin_xfer(0);
    cfg_num_vectors = 0; start = 1; mu_valid = 1; cgra_ready = 1;
    step();
    start = 0;
    #1;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_mu_ready", mu_ready, 0);
    chk("zero_issued", issued_cnt, 0);
    step();
    #1;
    chk("zero_done_once", done, 0);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_no_push", sb.size(), 0);

    // Abort with 7 issued and 3 buffered
    begin_xfer(20);
    cfg_num_vectors = 20; start = 1; mu_valid = 1; cgra_ready = 1;
    step();
    start = 0;
    n = 0;
    while (pops < 7 && n < 100) begin step(); n++; end
    cgra_ready = 0;
    n = 0;
    while (sb.size() < 3 && n < 20) begin step(); n++; end
    chk("abort_buffered", sb.size(), 3);
    mu_valid = 0; abort = 1;
    step();
    abort = 0;
    sb.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_cgra_valid", cgra_valid, 0);
    chk("abort_mu_ready", mu_ready, 0);
    chk("abort_issued", issued_cnt, 7);
    chk("abort_done", done, 0);
    repeat (3) step();
    chk("abort_no_done", done_cnt, 0);

    begin_xfer(2);
    cfg_num_vectors = 2; start = 1; mu_valid = 1; cgra_ready = 1;
    step();
    start = 0;
    run_until_done("post_abort", 30, 0);

    // Reset mid-RUN
    begin_xfer(10);
    cfg_num_vectors = 10; start = 1; mu_valid = 1; cgra_ready = 1;
    step();
    start = 0;
    repeat (3) step();
    reset = 1;
    step();
    reset = 0; mu_valid = 0; cgra_ready = 0;
    sb.delete();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_issued", issued_cnt, 0);
    chk("midrst_mu_ready", mu_ready, 0);
    chk("midrst_cgra_valid", cgra_valid, 0);
    chk("midrst_cgra_data", cgra_data, 0);

    // Start beats abort in IDLE; a start during RUN is ignored
    begin_xfer(3);
    cfg_num_vectors = 3; start = 1; abort = 1; mu_valid = 1; cgra_ready = 1;
    step();
    start = 0; abort = 0;
    #1;
    chk("start_wins", busy, 1);
    step();
    cfg_num_vectors = 1; start = 1;
    step();
    start = 0; cfg_num_vectors = 3;
    run_until_done("ignored_start", 30, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
